alu_req_scheduler: RTL and testbench

//   Shares one combinational 32-bit ALU (4-bit op select; Z/C/V/S flags) between NUM_REQ requesters.

---
 rtl/alu_req_scheduler.sv | 167 ++++++++++++++++
 tb/tb_alu_req_scheduler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler that shares one external combinational 32-bit ALU among NUM_REQ requesters.
// Optional divide-by-zero trap is enabled by defining ALU_SCHED_DIV0_TRAP_EN.
module alu_req_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [4*NUM_REQ-1:0]  req_sel,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_result,
   output logic [3:0]            rsp_flags,
   output logic                  rsp_err,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [3:0]            alu_sel,
   input  logic [31:0]           alu_out,
   input  logic                  alu_z,
   input  logic                  alu_c,
   input  logic                  alu_v,
   input  logic                  alu_s,
   output logic                  busy,
   output logic [1:0]            dbg_state_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             state_q;
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [PTR_W-1:0]   rr_ptr_d;
   logic [31:0]        alu_a_q;
   logic [31:0]        alu_b_q;
   logic [3:0]         alu_sel_q;
   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [31:0]        rsp_result_q;
   logic [3:0]         rsp_flags_q;

   logic [PTR_W-1:0]   scan_idx;
   logic [PTR_W-1:0]   win_idx;
   logic               win_found;
   logic [NUM_REQ-1:0] grant_onehot;
   logic [31:0]        win_a;
   logic [31:0]        win_b;
   logic [3:0]         win_sel;
   logic               accept;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // req_ready is offered only in IDLE to the round-robin winner; rsp_valid holds until rsp_ready.
   always_comb begin
      scan_idx  = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!win_found && req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      if (rst_n && (state_q == ST_IDLE) && win_found) begin
         grant_onehot[win_idx] = 1'b1;
      end
   end

   assign req_ready = grant_onehot;
   assign accept    = |grant_onehot;
   assign win_a     = req_a[int'(win_idx)*32 +: 32];
   assign win_b     = req_b[int'(win_idx)*32 +: 32];
   assign win_sel   = req_sel[int'(win_idx)*4 +: 4];
   assign rr_ptr_d  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

`ifdef ALU_SCHED_DIV0_TRAP_EN
   logic rsp_err_q;
   logic div0_trap;
   assign div0_trap = (win_sel == 4'd7) && (win_b == 32'd0);
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_sel_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
`ifdef ALU_SCHED_DIV0_TRAP_EN
         rsp_err_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  alu_a_q   <= win_a;
                  alu_b_q   <= win_b;
                  alu_sel_q <= win_sel;
                  rsp_id_q  <= ID_W'(win_idx);
                  rr_ptr_q  <= rr_ptr_d;
`ifdef ALU_SCHED_DIV0_TRAP_EN
                  if (div0_trap) begin
                     // Trap answers without waiting for the ALU.
                     rsp_result_q <= 32'hFFFF_FFFF;
                     rsp_flags_q  <= 4'b0000;
                     rsp_err_q    <= 1'b1;
                     rsp_valid_q  <= 1'b1;
                     state_q      <= ST_RESP;
                  end else begin
                     state_q <= ST_EXEC;
                  end
`else
                  state_q <= ST_EXEC;
`endif
               end
            end
            ST_EXEC: begin
               rsp_result_q <= alu_out;
               rsp_flags_q  <= {alu_z, alu_c, alu_v, alu_s};
`ifdef ALU_SCHED_DIV0_TRAP_EN
               rsp_err_q    <= 1'b0;
`endif
               rsp_valid_q  <= 1'b1;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_flags   = rsp_flags_q;
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed self-checking bench for alu_req_scheduler; includes a stand-in combinational ALU.
module tb_alu_req_scheduler;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_a = '0;
   logic [32*NUM_REQ-1:0] req_b = '0;
   logic [4*NUM_REQ-1:0]  req_sel = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b0;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_result;
   logic [3:0]            rsp_flags;
   logic                  rsp_err;
   logic [31:0]           alu_a;
   logic [31:0]           alu_b;
   logic [3:0]            alu_sel;
   logic [31:0]           alu_out;
   logic                  alu_z;
   logic                  alu_c;
   logic                  alu_v;
   logic                  alu_s;
   logic                  busy;
   logic [1:0]            dbg_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_req_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_s(alu_s),
      .busy(busy), .dbg_state_o(dbg_state)
   );

   // Stand-in ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 div, 8 mul, 9 not; others yield 0.
   always_comb begin
      alu_out = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu_sel)
         4'd0: begin
            {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            alu_v = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         4'd1: begin
            alu_out = alu_a - alu_b;
            alu_c   = (alu_a < alu_b);
            alu_v   = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
         end
         4'd2: alu_out = alu_a & alu_b;
         4'd3: alu_out = alu_a | alu_b;
         4'd4: alu_out = alu_a ^ alu_b;
         4'd5: alu_out = alu_a << alu_b[4:0];
         4'd6: alu_out = alu_a >> alu_b[4:0];
         4'd7: alu_out = (alu_b == 32'd0) ? 32'hFFFF_FFFF : alu_a / alu_b;
         4'd8: alu_out = alu_a * alu_b;
         4'd9: alu_out = ~alu_a;
         default: alu_out = '0;
      endcase
      alu_z = (alu_out == 32'd0);
      alu_s = alu_out[31];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel);
      req_a[32*id +: 32] = a;
      req_b[32*id +: 32] = b;
      req_sel[4*id +: 4] = sel;
      req_valid[id]      = 1'b1;
   endtask

   task automatic apply_reset();
      req_valid = '0;
      rsp_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Called 1 time unit after a rising edge; returns once rsp_valid is seen or a bound expires.
   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel, output bit ok, output int lat);
      int n;
      ok  = 1'b0;
      lat = 0;
      set_req(id, a, b, sel);
      #1;
      n = 0;
      while (!req_ready[id] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready[id]) begin
         req_valid[id] = 1'b0;
         return;
      end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      ok = rsp_valid;
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      @(posedge clk); #1;
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_id, rsp_flags, rsp_err, dbg_state} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b busy=%b id=%0d flags=%b err=%b state=%0d, expected all 0",
                  req_ready, rsp_valid, busy, rsp_id, rsp_flags, rsp_err, dbg_state);
      end
      checks++;
      if ({alu_a, alu_b, alu_sel, rsp_result} !== '0) begin
         errors++;
         $display("FAIL reset_data: got alu_a=%h alu_b=%h alu_sel=%h result=%h, expected all 0",
                  alu_a, alu_b, alu_sel, rsp_result);
      end
      req_valid = '0;
      rst_n     = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({busy, rsp_valid, req_ready} !== '0) begin
         errors++;
         $display("FAIL reset_release_idle: got busy=%b rsp_valid=%b ready=%b, expected 0 0 0000",
                  busy, rsp_valid, req_ready);
      end
   endtask

   task automatic test_single_op();
      set_req(0, 32'd5, 32'd7, 4'd0);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL single_ready: got %b expected 0001", req_ready);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      checks++;
      if ({rsp_valid, busy, dbg_state, alu_a, alu_b, alu_sel} !== {1'b0, 1'b1, 2'd1, 32'd5, 32'd7, 4'd0}) begin
         errors++;
         $display("FAIL single_exec: got rsp_valid=%b busy=%b state=%0d alu_a=%0d alu_b=%0d sel=%0d, expected 0 1 1 5 7 0",
                  rsp_valid, busy, dbg_state, alu_a, alu_b, alu_sel);
      end
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err} !== {1'b1, 2'd0, 32'd12, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL single_rsp: got valid=%b id=%0d result=%0d flags=%b err=%b, expected 1 0 12 0000 0",
                  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
      release_rsp();
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL single_done: got rsp_valid=%b busy=%b, expected 0 0", rsp_valid, busy);
      end
   endtask

   task automatic test_rr_fairness();
      int          exp_grant [5];
      logic [31:0] exp_res [4];
      logic [3:0]  exp_oh;
      int          n;
      exp_grant = '{0, 1, 2, 3, 0};
      exp_res   = '{32'd1000, 32'd2001, 32'd3002, 32'd4003};
      apply_reset();
      rsp_ready = 1'b1;
      set_req(0, 32'd1000, 32'd0, 4'd0);
      set_req(1, 32'd2000, 32'd1, 4'd0);
      set_req(2, 32'd3000, 32'd2, 4'd0);
      set_req(3, 32'd4000, 32'd3, 4'd0);
      #1;
      for (int g = 0; g < 5; g++) begin
         n = 0;
         while (req_ready == '0 && n < 10) begin
            @(posedge clk); #1;
            n++;
         end
         exp_oh = 4'b0001 << exp_grant[g];
         checks++;
         if (req_ready !== exp_oh) begin
            errors++;
            $display("FAIL rr_grant%0d: got ready=%b expected %b", g, req_ready, exp_oh);
         end
         @(posedge clk); #1;
         n = 0;
         while (!rsp_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
         end
         checks++;
         if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'(exp_grant[g]), exp_res[exp_grant[g]]}) begin
            errors++;
            $display("FAIL rr_rsp%0d: got valid=%b id=%0d result=%0d expected 1 %0d %0d",
                     g, rsp_valid, rsp_id, rsp_result, exp_grant[g], exp_res[exp_grant[g]]);
         end
      end
      req_valid = '0;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL rr_idle: got busy=%b rsp_valid=%b expected 0 0", busy, rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int lat;
      rsp_ready = 1'b0;
      issue(2, 32'd100, 32'd50, 4'd1, ok, lat);
      checks++;
      if (!ok || lat != 2) begin
         errors++;
         $display("FAIL bp_latency: got ok=%0d latency=%0d expected 1 2", ok, lat);
      end
      set_req(1, 32'd1, 32'd1, 4'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, busy} !==
             {1'b1, 2'd2, 32'd50, 4'b0000, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b id=%0d result=%0d flags=%b ready=%b busy=%b expected 1 2 50 0000 0000 1",
                     i, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, busy);
         end
      end
      release_rsp();
      checks++;
      if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
         errors++;
         $display("FAIL bp_release: got rsp_valid=%b ready=%b expected 0 0010", rsp_valid, req_ready);
      end
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         errors++;
         $display("FAIL bp_drop: got busy=%b rsp_valid=%b expected 0 0 after withdrawn request", busy, rsp_valid);
      end
   endtask

   task automatic test_flags();
      bit ok;
      int lat;
      issue(0, 32'h7FFF_FFFF, 32'd1, 4'd0, ok, lat);
      checks++;
      if (!ok || {rsp_result, rsp_flags} !== {32'h8000_0000, 4'b0011}) begin
         errors++;
         $display("FAIL flags_add_ovf: got ok=%0d result=%h flags=%b expected 80000000 0011", ok, rsp_result, rsp_flags);
      end
      release_rsp();
      issue(0, 32'd0, 32'd1, 4'd1, ok, lat);
      checks++;
      if (!ok || {rsp_result, rsp_flags} !== {32'hFFFF_FFFF, 4'b0101}) begin
         errors++;
         $display("FAIL flags_sub_borrow: got ok=%0d result=%h flags=%b expected ffffffff 0101", ok, rsp_result, rsp_flags);
      end
      release_rsp();
      issue(0, 32'd5, 32'd5, 4'hC, ok, lat);
      checks++;
      if (!ok || {rsp_result, rsp_flags, alu_sel} !== {32'd0, 4'b1000, 4'hC}) begin
         errors++;
         $display("FAIL flags_bad_op: got ok=%0d result=%h flags=%b sel=%h expected 0 1000 c", ok, rsp_result, rsp_flags, alu_sel);
      end
      release_rsp();
   endtask

   task automatic test_reset_mid_exec();
      bit ok;
      int n;
      int lat;
      set_req(1, 32'hDEAD_BEEF, 32'd1234, 4'd3);
      #1;
      n = 0;
      while (!req_ready[1] && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      req_valid = '0;
      checks++;
      if ({busy, dbg_state} !== {1'b1, 2'd1}) begin
         errors++;
         $display("FAIL rst_mid_pre: got busy=%b state=%0d expected 1 1", busy, dbg_state);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, rsp_valid, busy, rsp_id, rsp_flags, rsp_err, alu_a, alu_b, alu_sel, rsp_result} !== '0) begin
         errors++;
         $display("FAIL rst_mid_zero: got ready=%b valid=%b busy=%b id=%0d flags=%b err=%b alu_a=%h alu_b=%h sel=%h result=%h expected all 0",
                  req_ready, rsp_valid, busy, rsp_id, rsp_flags, rsp_err, alu_a, alu_b, alu_sel, rsp_result);
      end
      #10 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_norsp%0d: got rsp_valid=%b expected 0", i, rsp_valid);
         end
      end
      set_req(2, 32'd9, 32'd9, 4'd0);
      issue(0, 32'd3, 32'd4, 4'd0, ok, lat);
      req_valid = '0;
      checks++;
      if (!ok || {rsp_id, rsp_result} !== {2'd0, 32'd7}) begin
         errors++;
         $display("FAIL rst_mid_next_grant: got ok=%0d id=%0d result=%0d expected 0 7", ok, rsp_id, rsp_result);
      end
      release_rsp();
   endtask

   task automatic test_div0();
      bit ok;
      int lat;
      issue(3, 32'd100, 32'd0, 4'd7, ok, lat);
`ifdef ALU_SCHED_DIV0_TRAP_EN
      checks++;
      if (!ok || lat != 1 || {rsp_id, rsp_result, rsp_flags, rsp_err} !== {2'd3, 32'hFFFF_FFFF, 4'b0000, 1'b1}) begin
         errors++;
         $display("FAIL div0_trap: got ok=%0d lat=%0d id=%0d result=%h flags=%b err=%b expected lat 1 id 3 ffffffff 0000 1",
                  ok, lat, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
      checks++;
      if ({alu_a, alu_b, alu_sel} !== {32'd100, 32'd0, 4'd7}) begin
         errors++;
         $display("FAIL div0_operands: got alu_a=%0d alu_b=%0d sel=%0d expected 100 0 7", alu_a, alu_b, alu_sel);
      end
`else
      checks++;
      if (!ok || lat != 2 || {rsp_id, rsp_result, rsp_flags, rsp_err} !== {2'd3, 32'hFFFF_FFFF, 4'b0001, 1'b0}) begin
         errors++;
         $display("FAIL div0_passthru: got ok=%0d lat=%0d id=%0d result=%h flags=%b err=%b expected lat 2 id 3 ffffffff 0001 0",
                  ok, lat, rsp_id, rsp_result, rsp_flags, rsp_err);
      end
`endif
      release_rsp();
      issue(3, 32'd100, 32'd7, 4'd7, ok, lat);
      checks++;
      if (!ok || lat != 2 || {rsp_result, rsp_flags, rsp_err} !== {32'd14, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL div_normal: got ok=%0d lat=%0d result=%0d flags=%b err=%b expected lat 2 14 0000 0",
                  ok, lat, rsp_result, rsp_flags, rsp_err);
      end
      release_rsp();
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_rr_fairness();
      test_backpressure();
      test_flags();
      test_reset_mid_exec();
      test_div0();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
